// File: rtl/priv_1_12_trap_seq_if.sv
// Bundle between the pipeline/CSR file and the trap sequencer.
// The slave modport is the sequencer side; master is the pipeline/CSR side.
interface priv_1_12_trap_seq_if;
  logic        ex_req;
  logic [3:0]  ex_code;
  logic [31:0] ex_epc;
  logic [31:0] ex_tval;
  logic        mret_req;
  logic        int_ok;
  logic [31:0] int_epc;
  logic [31:0] curr_mstatus;
  logic [31:0] curr_mie;
  logic [31:0] curr_mip;
  logic [31:0] curr_mtvec;
  logic [31:0] curr_mepc;
  logic        inject_mcause;
  logic        inject_mepc;
  logic        inject_mtval;
  logic        inject_mstatus;
  logic [31:0] next_mcause;
  logic [31:0] next_mepc;
  logic [31:0] next_mtval;
  logic [31:0] next_mstatus;
  logic        busy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport slave (
    input  ex_req, ex_code, ex_epc, ex_tval, mret_req, int_ok, int_epc,
           curr_mstatus, curr_mie, curr_mip, curr_mtvec, curr_mepc,
    output inject_mcause, inject_mepc, inject_mtval, inject_mstatus,
           next_mcause, next_mepc, next_mtval, next_mstatus,
           busy, redirect_valid, redirect_pc
  );

  modport master (
    output ex_req, ex_code, ex_epc, ex_tval, mret_req, int_ok, int_epc,
           curr_mstatus, curr_mie, curr_mip, curr_mtvec, curr_mepc,
    input  inject_mcause, inject_mepc, inject_mtval, inject_mstatus,
           next_mcause, next_mepc, next_mtval, next_mstatus,
           busy, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/priv_1_12_trap_seq.sv
// Trap/MRET sequencer: one CSR inject per cycle, then a one-cycle PC redirect.
// Trap: IDLE>W_CAUSE>W_EPC>W_TVAL>W_STATUS>REDIR; MRET: IDLE>M_STATUS>REDIR.
module priv_1_12_trap_seq #(
  parameter bit VECTORED_EN = 1'b1
) (
  input logic CLK,
  input logic nRST,
  priv_1_12_trap_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, W_CAUSE, W_EPC, W_TVAL, W_STATUS, M_STATUS, REDIR
  } state_t;

  state_t      state_q, state_d;
  logic        is_int_q, is_int_d;
  logic        is_mret_q, is_mret_d;
  logic [3:0]  code_q, code_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] tval_q, tval_d;
  logic [31:0] mret_pc_q, mret_pc_d;

  logic        inj_mcause, inj_mepc, inj_mtval, inj_mstatus;
  logic [31:0] nxt_mcause, nxt_mepc, nxt_mtval, nxt_mstatus;
  logic        busy, redir_v;
  logic [31:0] redir_pc;

  logic [2:0]  pend;
  logic        int_take;
  logic [3:0]  int_code;
  logic [31:0] trap_tgt;

  // pend = {MEI, MTI, MSI}; priority MEI > MSI > MTI
  assign pend     = {bus.curr_mip[11], bus.curr_mip[7], bus.curr_mip[3]} &
                    {bus.curr_mie[11], bus.curr_mie[7], bus.curr_mie[3]};
  assign int_take = bus.curr_mstatus[3] & bus.int_ok & (|pend);
  assign int_code = pend[2] ? 4'd11 : (pend[0] ? 4'd3 : 4'd7);

  assign trap_tgt = {bus.curr_mtvec[31:2], 2'b00} +
                    ((VECTORED_EN && bus.curr_mtvec[1:0] == 2'b01 && is_int_q) ?
                     {26'b0, code_q, 2'b00} : 32'b0);

  always_comb begin
    state_d     = state_q;
    is_int_d    = is_int_q;
    is_mret_d   = is_mret_q;
    code_d      = code_q;
    epc_d       = epc_q;
    tval_d      = tval_q;
    mret_pc_d   = mret_pc_q;
    busy        = 1'b0;
    redir_v     = 1'b0;
    redir_pc    = 32'b0;
    inj_mcause  = 1'b0;
    inj_mepc    = 1'b0;
    inj_mtval   = 1'b0;
    inj_mstatus = 1'b0;
    nxt_mcause  = 32'b0;
    nxt_mepc    = 32'b0;
    nxt_mtval   = 32'b0;
    nxt_mstatus = 32'b0;
    case (state_q)
      IDLE: begin
        // nRST gating keeps busy low while reset is held
        if (nRST) begin
          if (bus.ex_req) begin
            busy      = 1'b1;
            is_int_d  = 1'b0;
            is_mret_d = 1'b0;
            code_d    = bus.ex_code;
            epc_d     = {bus.ex_epc[31:1], 1'b0};
            tval_d    = bus.ex_tval;
            state_d   = W_CAUSE;
          end else if (bus.mret_req) begin
            busy      = 1'b1;
            is_int_d  = 1'b0;
            is_mret_d = 1'b1;
            state_d   = M_STATUS;
          end else if (int_take) begin
            busy      = 1'b1;
            is_int_d  = 1'b1;
            is_mret_d = 1'b0;
            code_d    = int_code;
            epc_d     = {bus.int_epc[31:1], 1'b0};
            tval_d    = 32'b0;
            state_d   = W_CAUSE;
          end
        end
      end
      W_CAUSE: begin
        busy       = 1'b1;
        inj_mcause = 1'b1;
        nxt_mcause = {is_int_q, 27'b0, code_q};
        state_d    = W_EPC;
      end
      W_EPC: begin
        busy     = 1'b1;
        inj_mepc = 1'b1;
        nxt_mepc = epc_q;
        state_d  = W_TVAL;
      end
      W_TVAL: begin
        busy      = 1'b1;
        inj_mtval = 1'b1;
        nxt_mtval = tval_q;
        state_d   = W_STATUS;
      end
      W_STATUS: begin
        busy               = 1'b1;
        inj_mstatus        = 1'b1;
        nxt_mstatus        = bus.curr_mstatus;
        nxt_mstatus[7]     = bus.curr_mstatus[3];
        nxt_mstatus[3]     = 1'b0;
        nxt_mstatus[12:11] = 2'b11;
        state_d            = REDIR;
      end
      M_STATUS: begin
        busy               = 1'b1;
        inj_mstatus        = 1'b1;
        nxt_mstatus        = bus.curr_mstatus;
        nxt_mstatus[3]     = bus.curr_mstatus[7];
        nxt_mstatus[7]     = 1'b1;
        nxt_mstatus[12:11] = 2'b00;
        mret_pc_d          = bus.curr_mepc;
        state_d            = REDIR;
      end
      REDIR: begin
        busy     = 1'b1;
        redir_v  = 1'b1;
        redir_pc = is_mret_q ? mret_pc_q : trap_tgt;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      is_int_q  <= 1'b0;
      is_mret_q <= 1'b0;
      code_q    <= 4'b0;
      epc_q     <= 32'b0;
      tval_q    <= 32'b0;
      mret_pc_q <= 32'b0;
    end else begin
      state_q   <= state_d;
      is_int_q  <= is_int_d;
      is_mret_q <= is_mret_d;
      code_q    <= code_d;
      epc_q     <= epc_d;
      tval_q    <= tval_d;
      mret_pc_q <= mret_pc_d;
    end
  end

  assign bus.inject_mcause  = inj_mcause;
  assign bus.inject_mepc    = inj_mepc;
  assign bus.inject_mtval   = inj_mtval;
  assign bus.inject_mstatus = inj_mstatus;
  assign bus.next_mcause    = nxt_mcause;
  assign bus.next_mepc      = nxt_mepc;
  assign bus.next_mtval     = nxt_mtval;
  assign bus.next_mstatus   = nxt_mstatus;
  assign bus.busy           = busy;
  assign bus.redirect_valid = redir_v;
  assign bus.redirect_pc    = redir_pc;

  logic unused_bits;
  assign unused_bits = ^{bus.curr_mip[31:12], bus.curr_mip[10:8], bus.curr_mip[6:4],
                         bus.curr_mip[2:0], bus.curr_mie[31:12], bus.curr_mie[10:8],
                         bus.curr_mie[6:4], bus.curr_mie[2:0], bus.ex_epc[0],
                         bus.int_epc[0]};

endmodule

// File: doc/priv_1_12_trap_seq.md
# priv_1_12_trap_seq

Trap/return sequencer for the 1.12 privilege unit, sitting directly upstream of the M-mode CSR file. It accepts exception, interrupt and MRET requests from the pipeline and drives the CSR file's one-hot injection port one register per cycle, because the CSR file honours only one inject per cycle. It then issues a single-cycle PC redirect to the trap vector or to mepc, and holds the pipeline via `busy` for the whole sequence.

## Interface
Parameters:
- VECTORED_EN, 1, when 1, mtvec mode 1 (vectored) is honoured for interrupts; when 0, all traps go to base.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- ex_req  in  1  synchronous exception from pipeline (level; sampled only in IDLE)
- ex_code  in  4  exception cause code
- ex_epc  in  32  PC of faulting instruction
- ex_tval  in  32  trap value for exception
- mret_req  in  1  MRET retiring (sampled only in IDLE)
- int_ok  in  1  pipeline at instruction boundary, interrupt may be taken
- int_epc  in  32  PC to resume at after interrupt
- curr_mstatus, curr_mie, curr_mip, curr_mtvec, curr_mepc  in  32 each  current CSR values from CSR file
- inject_mcause, inject_mepc, inject_mtval, inject_mstatus  out  1 each  one-hot inject strobes to CSR file
- next_mcause, next_mepc, next_mtval, next_mstatus  out  32 each  inject data
- busy  out  1  stall request to pipeline
- redirect_valid  out  1  one-cycle PC redirect strobe
- redirect_pc  out  32  redirect target

## Operation
- Interrupt pending: `pend = curr_mip[11,7,3] & curr_mie[11,7,3]`; interrupt taken only if `curr_mstatus[3]` (MIE) and `int_ok` and `|pend`. Priority: MEI (code 11) > MSI (3) > MTI (7).
- IDLE arbitration, highest first: ex_req > mret_req > interrupt. Losers are not recorded; they must still be present on a later IDLE cycle to be taken.
- On accept, latch: is_int, code (4b), epc, tval. Exception: epc = ex_epc with bit 0 cleared, tval = ex_tval. Interrupt: epc = int_epc with bit 0 cleared, tval = 0.
- FSM states: IDLE, W_CAUSE, W_EPC, W_TVAL, W_STATUS, M_STATUS, REDIR.
  - Trap path: IDLE -> W_CAUSE -> W_EPC -> W_TVAL -> W_STATUS -> REDIR -> IDLE.
  - MRET path: IDLE -> M_STATUS -> REDIR -> IDLE.
- W_CAUSE: next_mcause = {is_int, 27'b0, code}.
- W_EPC: next_mepc = latched epc.
- W_TVAL: next_mtval = latched tval.
- W_STATUS: next_mstatus = curr_mstatus with MPIE[7] = MIE[3], MIE[3] = 0, MPP[12:11] = 2'b11.
- M_STATUS: next_mstatus = curr_mstatus with MIE[3] = MPIE[7], MPIE[7] = 1, MPP[12:11] = 2'b00. In this state also latch redirect target = curr_mepc.
- Exactly one inject strobe is high in each W_*/M_STATUS state, none elsewhere. next_* outputs are 0 when their strobe is low.
- REDIR, trap: base = {curr_mtvec[31:2], 2'b00}. If VECTORED_EN and curr_mtvec[1:0] == 01 and is_int, target = base + 4*code; otherwise target = base. Addition is 32-bit, wraps mod 2^32.
- REDIR, MRET: target = latched mepc.

## Timing
- Reset: state IDLE; busy, redirect_valid and all inject strobes = 0; redirect_pc and all next_* = 0; latches cleared. Reset asserted mid-sequence aborts immediately; no further injects occur.
- busy is combinational: high in IDLE in the accepting cycle, and high in every non-IDLE state. busy = 0 in IDLE with no accept.
- Trap latency: accept cycle N; injects at N+1..N+4; redirect_valid at N+5; busy falls after N+5.
- MRET latency: inject at N+1; redirect_valid at N+2.
- redirect_valid pulses for exactly one cycle. redirect_pc is valid only while redirect_valid = 1, else 0.
- Request inputs are ignored in every non-IDLE state, including REDIR. A new accept is possible at the cycle after REDIR.
- W_STATUS reads curr_mstatus at that cycle, which is unaffected by the prior three injects.

## Test plan
- Reset mid-trap: assert nRST low in W_EPC -> all outputs 0 next edge; no inject_mtval/inject_mstatus after release.
- Exception: ex_req=1, ex_code=2, ex_epc=0x100, ex_tval=0xDEADBEEF, mtvec=0x8000_0000, mstatus=0x8 -> mcause=0x2, mepc=0x100, mtval=0xDEADBEEF, mstatus=0x1880 on consecutive cycles; redirect 0x8000_0000 at N+5.
- Vectored interrupt: mip=mie=0x888, mstatus.MIE=1, int_ok=1, mtvec=0x1001, int_epc=0x204 -> mcause=0x8000_000B, mtval=0, redirect 0x102C. Repeat with mstatus.MIE=0 or int_ok=0 -> no accept, busy=0.
- MRET: mstatus=0x1880, mepc=0x300 -> mstatus=0x88 at N+1; redirect 0x300 at N+2; busy high for 3 cycles.
- Simultaneous: ex_req + mret_req + pending MTI together -> exception sequence only; requests asserted during busy are ignored; MTI (held) taken at cycle after REDIR with mcause=0x8000_0007.
